// File: rtl/bsg_manycore_endpoint_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_manycore_endpoint_req_arbiter_pkg
//  Brief    : Shared types and helpers for the endpoint request arbiter.
//  Revision : 1.0
// ============================================================================
package bsg_manycore_endpoint_req_arbiter_pkg;

    localparam int unsigned c_max_pkt_w = 1024;
    localparam int unsigned c_max_id_w  = 8;

    typedef struct packed {
        logic idle;
        logic err;
    } arb_status_t;

    // Returns the WIDTH-bit field starting at LSB, zero-extended to c_max_id_w.
    function automatic logic [c_max_id_w-1:0] client_id(
        input logic [c_max_pkt_w-1:0] pkt,
        input int unsigned            lsb,
        input int unsigned            width
    );
        logic [c_max_id_w-1:0] id;
        id = '0;
        for (int unsigned b = 0; b < c_max_id_w; b++) begin
            if (b < width) begin
                id[3'(b)] = pkt[10'(lsb + b)];
            end
        end
        return id;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bsg_manycore_endpoint_req_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_manycore_endpoint_req_arbiter_if
//  Brief    : Client, endpoint and network-response bundle of the arbiter.
//  Revision : 1.0
// ============================================================================
interface bsg_manycore_endpoint_req_arbiter_if #(
    parameter int unsigned NUM_CLIENTS     = 4,
    parameter int unsigned FIFO_WIDTH      = 128,
    parameter int unsigned MAX_OUT_CREDITS = 32
);
    localparam int unsigned c_credit_w = $clog2(MAX_OUT_CREDITS + 1);

    logic [NUM_CLIENTS-1:0]            client_req_v_i;
    logic [NUM_CLIENTS*FIFO_WIDTH-1:0] client_req_data_i;
    logic [NUM_CLIENTS-1:0]            client_req_ready_o;
    logic [NUM_CLIENTS-1:0]            client_rsp_v_o;
    logic [FIFO_WIDTH-1:0]             client_rsp_data_o;
    logic [NUM_CLIENTS-1:0]            client_rsp_ready_i;
    logic                              endpoint_req_v_o;
    logic [FIFO_WIDTH-1:0]             endpoint_req_data_o;
    logic                              endpoint_req_ready_i;
    logic                              mc_rsp_v_i;
    logic [FIFO_WIDTH-1:0]             mc_rsp_data_i;
    logic                              mc_rsp_ready_o;
    logic [c_credit_w-1:0]             out_credits_i;
    logic                              idle_o;
    logic                              err_o;

    modport slave (
        input  client_req_v_i, client_req_data_i, client_rsp_ready_i,
        input  endpoint_req_ready_i, mc_rsp_v_i, mc_rsp_data_i, out_credits_i,
        output client_req_ready_o, client_rsp_v_o, client_rsp_data_o,
        output endpoint_req_v_o, endpoint_req_data_o, mc_rsp_ready_o,
        output idle_o, err_o
    );

    modport master (
        output client_req_v_i, client_req_data_i, client_rsp_ready_i,
        output endpoint_req_ready_i, mc_rsp_v_i, mc_rsp_data_i, out_credits_i,
        input  client_req_ready_o, client_rsp_v_o, client_rsp_data_o,
        input  endpoint_req_v_o, endpoint_req_data_o, mc_rsp_ready_o,
        input  idle_o, err_o
    );

endinterface
`default_nettype wire

// File: rtl/bsg_manycore_endpoint_req_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_manycore_endpoint_req_arbiter_rr
//  Brief    : Round-robin arbiter; pointer moves past the winner on yumi.
//  Revision : 1.0
// ============================================================================
module bsg_manycore_endpoint_req_arbiter_rr #(
    parameter  int unsigned NUM_CLIENTS = 4,
    localparam int unsigned c_id_w      = $clog2(NUM_CLIENTS)
) (
    input  wire logic                   clk_i,
    input  wire logic                   reset_i,
    input  wire logic [NUM_CLIENTS-1:0] reqs_i,
    input  wire logic                   yumi_i,
    output logic      [NUM_CLIENTS-1:0] grants_o,
    output logic      [c_id_w-1:0]      tag_o,
    output logic                        v_o
);

    logic [c_id_w-1:0] ptr_q;
    logic [c_id_w-1:0] ptr_d;

    always_comb begin
        logic [c_id_w:0]   sum;
        logic [c_id_w-1:0] idx;
        logic              found;
        grants_o = '0;
        tag_o    = '0;
        found    = 1'b0;
        sum      = '0;
        idx      = '0;
        // Scan clients in priority order starting from the pointer.
        for (int o = 0; o < NUM_CLIENTS; o++) begin
            sum = {1'b0, ptr_q} + (c_id_w+1)'(o);
            if (sum >= (c_id_w+1)'(NUM_CLIENTS)) begin
                sum = sum - (c_id_w+1)'(NUM_CLIENTS);
            end
            idx = sum[c_id_w-1:0];
            if (!found && reqs_i[idx]) begin
                found         = 1'b1;
                tag_o         = idx;
                grants_o[idx] = 1'b1;
            end
        end
        v_o = found;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (yumi_i && v_o) begin
            ptr_d = (tag_o == c_id_w'(NUM_CLIENTS - 1)) ? '0 : tag_o + c_id_w'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bsg_manycore_endpoint_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_manycore_endpoint_req_arbiter
//  Brief    : Shares one endpoint FIFO port among clients with credit gating
//             and id-based response demux.
//  Revision : 1.0
// ============================================================================
module bsg_manycore_endpoint_req_arbiter
    import bsg_manycore_endpoint_req_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS     = 4,
    parameter int unsigned FIFO_WIDTH      = 128,
    parameter int unsigned MAX_OUT_CREDITS = 32,
    parameter int unsigned CLIENT_CREDITS  = 8,
    parameter int unsigned REQ_ID_LSB      = 0,
    parameter int unsigned RSP_ID_LSB      = 0
) (
    input wire logic                           clk_i,
    input wire logic                           reset_i,
    bsg_manycore_endpoint_req_arbiter_if.slave io
);

    localparam int unsigned c_id_w     = $clog2(NUM_CLIENTS);
    localparam int unsigned c_cnt_w    = $clog2(CLIENT_CREDITS + 1);
    localparam int unsigned c_credit_w = $clog2(MAX_OUT_CREDITS + 1);

    logic [FIFO_WIDTH-1:0]  w_client_data [NUM_CLIENTS];
    logic [NUM_CLIENTS-1:0] w_eligible;
    logic [NUM_CLIENTS-1:0] w_grants;
    logic [c_id_w-1:0]      w_grant_tag;
    logic                   w_grant_v;
    logic                   w_drain;
    logic                   w_orb_free;
    logic [c_credit_w-1:0]  w_credit_need;
    logic                   w_credit_ok;
    logic [c_max_id_w-1:0]  w_rsp_id_full;
    logic [c_max_id_w-1:0]  w_req_id_full;
    logic [c_id_w-1:0]      w_rsp_id;
    logic                   w_rsp_in_range;
    logic [NUM_CLIENTS-1:0] w_rsp_onehot;
    logic [NUM_CLIENTS-1:0] w_delivered;
    logic                   w_zero_hit;
    logic                   w_any_out;
    arb_status_t            w_status;

    logic                   orb_v_q, orb_v_d;
    logic [FIFO_WIDTH-1:0]  orb_data_q, orb_data_d;
    logic [c_cnt_w-1:0]     cnt_q [NUM_CLIENTS];
    logic [c_cnt_w-1:0]     cnt_d [NUM_CLIENTS];
    logic                   err_q, err_d;

    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_unpack
        assign w_client_data[i] = io.client_req_data_i[i*FIFO_WIDTH +: FIFO_WIDTH];
    end

    // One packet sitting in the ORB has not yet been debited by the endpoint.
    assign w_drain       = orb_v_q & io.endpoint_req_ready_i;
    assign w_orb_free    = ~orb_v_q | w_drain;
    assign w_credit_need = (orb_v_q & ~w_drain) ? c_credit_w'(1) : '0;
    assign w_credit_ok   = (io.out_credits_i > w_credit_need);

    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_elig
        assign w_eligible[i] = io.client_req_v_i[i]
                             & (cnt_q[i] < c_cnt_w'(CLIENT_CREDITS))
                             & w_credit_ok
                             & w_orb_free;
    end

    bsg_manycore_endpoint_req_arbiter_rr #(
        .NUM_CLIENTS (NUM_CLIENTS)
    ) u_rr (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .reqs_i   (w_eligible),
        .yumi_i   (w_grant_v),
        .grants_o (w_grants),
        .tag_o    (w_grant_tag),
        .v_o      (w_grant_v)
    );

    assign io.client_req_ready_o  = w_grants;
    assign io.endpoint_req_v_o    = orb_v_q;
    assign io.endpoint_req_data_o = orb_data_q;

    always_comb begin
        orb_v_d    = orb_v_q;
        orb_data_d = orb_data_q;
        if (w_grant_v) begin
            orb_v_d    = 1'b1;
            orb_data_d = w_client_data[w_grant_tag];
        end else if (w_drain) begin
            orb_v_d    = 1'b0;
        end
    end

    // Response demux; ids outside the client range are swallowed.
    assign w_rsp_id_full  = client_id(c_max_pkt_w'(io.mc_rsp_data_i), RSP_ID_LSB, c_id_w);
    assign w_rsp_in_range = (w_rsp_id_full < c_max_id_w'(NUM_CLIENTS));
    assign w_rsp_id       = w_rsp_id_full[c_id_w-1:0];
    assign w_rsp_onehot   = (io.mc_rsp_v_i & w_rsp_in_range)
                          ? (NUM_CLIENTS'(1) << w_rsp_id) : '0;
    assign w_delivered    = w_rsp_onehot & io.client_rsp_ready_i;

    assign io.client_rsp_v_o    = w_rsp_onehot;
    assign io.client_rsp_data_o = io.mc_rsp_data_i;
    assign io.mc_rsp_ready_o    = w_rsp_in_range ? io.client_rsp_ready_i[w_rsp_id] : 1'b1;

    always_comb begin
        w_zero_hit = 1'b0;
        w_any_out  = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (w_grants[i] && !w_delivered[i]) begin
                cnt_d[i] = cnt_q[i] + c_cnt_w'(1);
            end else if (w_delivered[i] && !w_grants[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - c_cnt_w'(1);
            end
            if (w_delivered[i] && (cnt_q[i] == '0)) begin
                w_zero_hit = 1'b1;
            end
            if (cnt_q[i] != '0) begin
                w_any_out = 1'b1;
            end
        end
    end

    assign err_d = err_q | (io.mc_rsp_v_i & ~w_rsp_in_range) | w_zero_hit;

    assign w_status.idle = ~orb_v_q & ~w_any_out;
    assign w_status.err  = err_q;
    assign io.idle_o     = w_status.idle;
    assign io.err_o      = w_status.err;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            orb_v_q    <= 1'b0;
            orb_data_q <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            orb_v_q    <= orb_v_d;
            orb_data_q <= orb_data_d;
            err_q      <= err_d;
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Clients are expected to stamp their own index into each request.
    assign w_req_id_full = client_id(c_max_pkt_w'(w_client_data[w_grant_tag]), REQ_ID_LSB, c_id_w);

    a_req_id: assert property (@(posedge clk_i) disable iff (reset_i)
        w_grant_v |-> (w_req_id_full == c_max_id_w'(w_grant_tag)));

endmodule
`default_nettype wire

// File: tb/tb_bsg_manycore_endpoint_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bsg_manycore_endpoint_req_arbiter
//  Brief    : Directed and random stimulus against a behavioural model.
//  Revision : 1.0
// ============================================================================
module tb_bsg_manycore_endpoint_req_arbiter;

    localparam int N   = 4;
    localparam int W   = 128;
    localparam int MOC = 32;
    localparam int CC  = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bsg_manycore_endpoint_req_arbiter_if #(
        .NUM_CLIENTS(N), .FIFO_WIDTH(W), .MAX_OUT_CREDITS(MOC)
    ) u_if ();

    bsg_manycore_endpoint_req_arbiter #(
        .NUM_CLIENTS(N), .FIFO_WIDTH(W), .MAX_OUT_CREDITS(MOC),
        .CLIENT_CREDITS(CC), .REQ_ID_LSB(0), .RSP_ID_LSB(0)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .io      (u_if)
    );

    // Reference state
    int              m_ptr;
    int              m_cnt [N];
    bit              m_orb_v;
    logic [W-1:0]    m_orb_data;
    bit              m_err;

    // Stimulus for the next cycle
    logic [N-1:0]    s_req_v;
    logic [W-1:0]    s_req_data [N];
    bit              s_ep_ready;
    int              s_credits;
    bit              s_rsp_v;
    int              s_rsp_id;
    logic [N-1:0]    s_rsp_ready;

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_orb_v = 1'b0;
        m_orb_data = '0;
        m_err   = 1'b0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    task automatic quiet_inputs();
        s_req_v     = '0;
        s_ep_ready  = 1'b1;
        s_credits   = MOC;
        s_rsp_v     = 1'b0;
        s_rsp_id    = 0;
        s_rsp_ready = '1;
    endtask

    task automatic drive();
        logic [N*W-1:0] flat;
        logic [W-1:0]   rsp;
        for (int i = 0; i < N; i++) begin
            s_req_data[i] = {$urandom, $urandom, $urandom, $urandom};
            s_req_data[i][1:0] = 2'(i);
            flat[i*W +: W] = s_req_data[i];
        end
        rsp = {$urandom, $urandom, $urandom, $urandom};
        rsp[1:0] = 2'(s_rsp_id);
        u_if.client_req_v_i       = s_req_v;
        u_if.client_req_data_i    = flat;
        u_if.endpoint_req_ready_i = s_ep_ready;
        u_if.out_credits_i        = 6'(s_credits);
        u_if.mc_rsp_v_i           = s_rsp_v;
        u_if.mc_rsp_data_i        = rsp;
        u_if.client_rsp_ready_i   = s_rsp_ready;
    endtask

    // One cycle: drive at the falling edge, check, advance the model, clock.
    task automatic step();
        bit drain, free, deliver, all0, inc, dec;
        int need, g, idx;
        drive();
        #1;
        drain = m_orb_v && s_ep_ready;
        free  = !m_orb_v || drain;
        need  = (m_orb_v && !drain) ? 1 : 0;
        g = -1;
        for (int o = 0; o < N; o++) begin
            idx = (m_ptr + o) % N;
            if (g < 0 && s_req_v[idx] && m_cnt[idx] < CC && s_credits > need && free) g = idx;
        end
        all0 = 1'b1;
        for (int i = 0; i < N; i++) if (m_cnt[i] != 0) all0 = 1'b0;

        check("req_ready", W'(u_if.client_req_ready_o), (g >= 0) ? W'(1 << g) : '0);
        check("ep_v", W'(u_if.endpoint_req_v_o), W'(m_orb_v));
        if (m_orb_v) check("ep_data", u_if.endpoint_req_data_o, m_orb_data);
        check("rsp_v", W'(u_if.client_rsp_v_o), s_rsp_v ? W'(1 << s_rsp_id) : '0);
        check("rsp_data", u_if.client_rsp_data_o, u_if.mc_rsp_data_i);
        check("mc_rsp_ready", W'(u_if.mc_rsp_ready_o), W'(s_rsp_ready[s_rsp_id]));
        check("idle", W'(u_if.idle_o), W'(!m_orb_v && all0));
        check("err", W'(u_if.err_o), W'(m_err));

        deliver = s_rsp_v && s_rsp_ready[s_rsp_id];
        if (deliver && m_cnt[s_rsp_id] == 0) m_err = 1'b1;
        for (int i = 0; i < N; i++) begin
            inc = (g == i);
            dec = deliver && (s_rsp_id == i);
            if (inc && !dec) m_cnt[i]++;
            else if (dec && !inc && m_cnt[i] > 0) m_cnt[i]--;
        end
        if (g >= 0) begin
            m_orb_v    = 1'b1;
            m_orb_data = s_req_data[g];
            m_ptr      = (g + 1) % N;
        end else if (drain) begin
            m_orb_v = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic return_all();
        int n;
        s_req_v     = '0;
        s_ep_ready  = 1'b1;
        s_rsp_ready = '1;
        for (int i = 0; i < N; i++) begin
            n = m_cnt[i];
            repeat (n) begin
                s_rsp_v  = 1'b1;
                s_rsp_id = i;
                step();
            end
        end
        s_rsp_v = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1;
        model_reset();
        quiet_inputs();
        drive();
        #1;
        check("rst_ep_v", W'(u_if.endpoint_req_v_o), '0);
        check("rst_idle", W'(u_if.idle_o), W'(1));
        check("rst_err", W'(u_if.err_o), '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Single client, three back-to-back packets, then their responses
        s_req_v = 4'b0100;
        repeat (3) step();
        s_req_v = '0;
        repeat (2) step();
        s_rsp_v = 1'b1; s_rsp_id = 2;
        repeat (3) step();
        s_rsp_v = 1'b0;
        step();
        check("single_idle", W'(u_if.idle_o), W'(1));

        // Fairness with every client requesting
        s_req_v = '1;
        repeat (12) step();
        return_all();

        // Credit gating: no credits, then ORB stalled with one credit
        s_req_v = '1; s_credits = 0;
        repeat (3) step();
        s_credits = MOC; s_ep_ready = 1'b0;
        step();
        s_credits = 1;
        repeat (3) step();
        s_credits = MOC; s_ep_ready = 1'b1;
        return_all();

        // Per-client outstanding limit
        s_req_v = 4'b0001;
        repeat (10) step();
        s_req_v = 4'b0011;
        step();
        s_req_v = 4'b0001; s_rsp_v = 1'b1; s_rsp_id = 0;
        step();
        s_rsp_v = 1'b0;
        step();
        return_all();

        // Response backpressure, then a response to a client with nothing out
        s_req_v = 4'b0010;
        step();
        s_req_v = '0;
        step();
        s_rsp_v = 1'b1; s_rsp_id = 1; s_rsp_ready = 4'b1101;
        repeat (3) step();
        s_rsp_ready = '1;
        step();
        s_rsp_id = 3;
        step();
        s_rsp_v = 1'b0;
        repeat (2) step();
        check("err_sticky", W'(u_if.err_o), W'(1));

        // Asynchronous reset while the ORB holds a packet
        s_req_v = 4'b0001; s_ep_ready = 1'b0;
        step();
        #2;
        reset = 1'b1;
        #1;
        check("arst_ep_v", W'(u_if.endpoint_req_v_o), '0);
        check("arst_idle", W'(u_if.idle_o), W'(1));
        check("arst_err", W'(u_if.err_o), '0);
        model_reset();
        quiet_inputs();
        drive();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Random traffic
        for (int t = 0; t < 400; t++) begin
            s_req_v    = 4'($urandom);
            s_ep_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       s_credits = 0;
                1:       s_credits = 1;
                2:       s_credits = 2;
                default: s_credits = MOC;
            endcase
            s_rsp_v     = ($urandom_range(0, 2) == 0);
            s_rsp_id    = $urandom_range(0, N - 1);
            s_rsp_ready = 4'($urandom | $urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
